uart_rx_sys: RTL and testbench
==============================

Name: uart_rx_sys

Overview:
- Receive-side counterpart of the sensor board's UART transmit path.
- Oversamples an asynchronous 8N1 serial line on the system clock, validates the start bit, majority-votes each bit and recovers the byte LSB first.
- Presents the byte in a holding register with a valid/read handshake, plus framing-error and overrun flags.
- Sits between the board's receive pin and the host-command logic. It generates its own oversample tick; no separate baud-clock module is needed.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 38400: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 8.
- TICK_DIV, CLK_HZ/(BAUD*OVERSAMPLE): clocks per sample tick. Integer division, truncated; 81 at the defaults.

Ports:
- clock, input, 1: system clock; all flops are rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- rxPin, input, 1: serial line, idle high; asynchronous to clock.
- read, input, 1: host acknowledge, sampled each clock.
- data, output, 8: last good received byte.
- dataValid, output, 1: data holds an unread byte.
- frameError, output, 1: last completed frame had a low stop bit.
- overrun, output, 1: a good frame was dropped because dataValid was still set.
- busy, output, 1: high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous) clears the following, with no partial-frame effects:
  - data=0, dataValid=0, frameError=0, overrun=0, busy=0.
  - State=IDLE; all counters cleared.
  - Synchronizer flops set to 1.
- Input conditioning:
  - rxPin passes through a 2-flop synchronizer; all logic uses the synchronized value rxS.
  - A falling edge is detected from rxS and one extra registered copy.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits a 1-cycle tick at the wrap.
  - The tick counter is cleared in IDLE, so the first tick arrives TICK_DIV clocks after start detection.
- Sample counter sc:
  - Counts 0..OVERSAMPLE-1 on ticks and wraps to 0.
  - MID = OVERSAMPLE/2 - 1.
  - Vote = majority of rxS at ticks MID-1, MID and MID+1 of the bit; the bit value is registered at tick MID+1.
- State machine:
  - IDLE: on a falling edge of rxS, go to START and clear sc and the tick counter.
  - START: at the start-bit vote, a 1 means a glitch: return to IDLE with no flag change. A 0 means wait to the end of the bit (sc wrap), then go to DATA.
  - DATA: shift the voted bit into the MSB of an 8-bit shift register (LSB first on the wire). After 8 bits (bit counter 0..7), go to STOP at the end of the bit.
  - STOP: at the stop-bit vote (tick MID+1):
    - Vote 1: frameError<=0; the good-frame handling below applies; return to IDLE immediately (half-bit early, allowing back-to-back frames).
    - Vote 0: frameError<=1; data and dataValid are unchanged; go to BRK.
  - BRK: wait for rxS=1, then go to IDLE. This prevents a break condition from retriggering.
- Good-frame handling:
  - dataValid=0, or read=1 in the same cycle: data<=shift register, dataValid<=1, overrun unchanged.
  - dataValid=1 and read=0: the byte is discarded, data is kept, overrun<=1.
- Read rules:
  - read with dataValid=1 clears dataValid and overrun on the next edge, unless a good frame completes in the same cycle (see above).
  - read with dataValid=0 is ignored.
  - frameError is not cleared by read; only the next completed frame or reset changes it.
- Latency: dataValid rises about 9.5 bit times after the falling start edge, plus 3 clocks for the synchronizer and edge detect, plus up to TICK_DIV clocks.
- Rate tolerance: majority voting at mid-bit supports total clock/baud mismatch of at least ±3%.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16, so TICK_DIV=10 and 160 clocks/bit.
- Frame 0xA5, good stop bit -> data=0xA5, dataValid=1, frameError=0 about 1520 clocks after the start edge; read pulse -> dataValid=0 next cycle.
- Low pulse of 40 clocks on an idle line -> state returns to IDLE, busy drops, dataValid=0, no flag set.
- Frame 0x3C with stop bit held low for 3 bit times, then 0x81 -> frameError=1, dataValid=0 while low. On 0x81: data=0x81, dataValid=1, frameError=0.
- Back-to-back 0x11 then 0x22 with no read -> data=0x11, overrun=1. Then read -> dataValid=0, overrun=0.
- Frame 0x55 completing with read asserted in the same cycle as the stop vote (dataValid=1 holding 0x11) -> data=0x55, dataValid=1, overrun=0.
- Assert reset during DATA bit 4 of 0xF0 -> all outputs 0 asynchronously. After release, the next frame 0x0F is received correctly with no stale bits.
- Repeat the 0xA5 frame with line bit time scaled by 0.97 and by 1.03 -> data=0xA5 in both cases.

Source files
------------

// File: rtl/uart_rx_sys.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote at mid-bit,
// one-byte holding register with valid/read handshake, framing-error and overrun flags.
module uart_rx_sys #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 38400,
   parameter int OVERSAMPLE = 16,
   parameter int TICK_DIV   = CLK_HZ / (BAUD * OVERSAMPLE)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxPin,
   input  logic       read,
   output logic [7:0] data,
   output logic       dataValid,
   output logic       frameError,
   output logic       overrun,
   output logic       busy
);

   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2 - 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SC_V0     = SW'(MID - 1);
   localparam logic [SW-1:0] SC_V1     = SW'(MID);
   localparam logic [SW-1:0] SC_V2     = SW'(MID + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   // Handshake: dataValid stays high until a cycle with read=1 consumes the byte;
   // read while dataValid=0 has no effect.
   state_t        state, state_nx;
   logic          rx_m, rx_s, rx_d;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] sc;
   logic [2:0]    bitcnt;
   logic          v0, v1;
   logic [7:0]    shreg;
   logic          fall, tick, vote_pt, wrap, vote;
   logic          shift_en, good_frame, bad_frame;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rxPin;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall    = rx_d & ~rx_s;
   assign tick    = (state != IDLE) && (tcnt == TICK_LAST);
   assign vote_pt = tick && (sc == SC_V2);
   assign wrap    = tick && (sc == SC_LAST);
   assign vote    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (fall) state_nx = START;
         START: begin
            if (vote_pt && vote)  state_nx = IDLE;
            else if (wrap)        state_nx = DATA;
         end
         DATA:  if (wrap && bitcnt == 3'd7) state_nx = STOP;
         STOP:  if (vote_pt) state_nx = vote ? IDLE : BRK;
         BRK:   if (rx_s) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      shift_en   = (state == DATA) && vote_pt;
      good_frame = (state == STOP) && vote_pt && vote;
      bad_frame  = (state == STOP) && vote_pt && !vote;
   end

   // Timing counters restart from zero on every start edge so bit centres line up.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt   <= '0;
         sc     <= '0;
         bitcnt <= '0;
         v0     <= 1'b1;
         v1     <= 1'b1;
         shreg  <= '0;
      end else begin
         if (state == IDLE)          tcnt <= '0;
         else if (tcnt == TICK_LAST) tcnt <= '0;
         else                        tcnt <= tcnt + 1'b1;

         if (state == IDLE) sc <= '0;
         else if (tick)     sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;

         if (state != DATA) bitcnt <= '0;
         else if (wrap)     bitcnt <= bitcnt + 1'b1;

         if (tick && sc == SC_V0) v0 <= rx_s;
         if (tick && sc == SC_V1) v1 <= rx_s;
         if (shift_en) shreg <= {vote, shreg[7:1]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data       <= '0;
         dataValid  <= 1'b0;
         frameError <= 1'b0;
         overrun    <= 1'b0;
      end else if (good_frame) begin
         frameError <= 1'b0;
         if (!dataValid || read) begin
            data      <= shreg;
            dataValid <= 1'b1;
         end else begin
            overrun   <= 1'b1;
         end
      end else begin
         if (bad_frame) frameError <= 1'b1;
         if (read && dataValid) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sys.sv
// Bench for uart_rx_sys: frame-level reference model feeds an expected-output queue,
// a monitor compares every change of the output register set against it.
module tb_uart_rx_sys;
   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 10000;
   localparam int OS     = 16;
   localparam int BIT    = 160;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rxPin = 1'b1;
   logic       read  = 1'b0;
   logic [7:0] data;
   logic       dataValid, frameError, overrun, busy;

   uart_rx_sys #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
      .clock(clock), .reset(reset), .rxPin(rxPin), .read(read),
      .data(data), .dataValid(dataValid), .frameError(frameError),
      .overrun(overrun), .busy(busy)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Snapshot layout: {dataValid, frameError, overrun, data}
   logic [10:0] exp_q[$];
   logic [10:0] m_last = '0;
   logic [7:0]  m_data = '0;
   logic        m_dv = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

   function automatic void push_model();
      logic [10:0] snap;
      snap = {m_dv, m_fe, m_ov, m_data};
      if (snap != m_last) begin
         exp_q.push_back(snap);
         m_last = snap;
      end
   endfunction

   function automatic void model_good(input logic [7:0] b, input logic read_same);
      m_fe = 1'b0;
      if (!m_dv || read_same) begin
         m_data = b;
         m_dv   = 1'b1;
      end else begin
         m_ov = 1'b1;
      end
      push_model();
   endfunction

   function automatic void model_bad();
      m_fe = 1'b1;
      push_model();
   endfunction

   function automatic void model_read();
      if (m_dv) begin
         m_dv = 1'b0;
         m_ov = 1'b0;
      end
      push_model();
   endfunction

   function automatic void model_reset();
      m_data = '0; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      push_model();
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic drive_level(input logic v, input int n);
      rxPin = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_data(input logic [7:0] b, input int bc);
      @(negedge clock);
      drive_level(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_level(b[i], bc);
   endtask

   task automatic send_frame(input logic [7:0] b, input int bc);
      send_data(b, bc);
      drive_level(1'b1, bc);
   endtask

   task automatic do_read();
      model_read();
      read = 1'b1;
      @(negedge clock);
      read = 1'b0;
   endtask

   // Monitor: every change of the visible output set must match the next queued snapshot
   initial begin
      logic [10:0] prev, cur, e;
      prev = '0;
      forever begin
         @(negedge clock);
         cur = {dataValid, frameError, overrun, data};
         if (cur !== prev) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL out_change: got dv=%b fe=%b ov=%b data=%02h, expected no change",
                        cur[10], cur[9], cur[8], cur[7:0]);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  fails++;
                  $display("FAIL out_snapshot: got dv=%b fe=%b ov=%b data=%02h, expected dv=%b fe=%b ov=%b data=%02h",
                           cur[10], cur[9], cur[8], cur[7:0], e[10], e[9], e[8], e[7:0]);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      int lat;
      int w;
      logic [7:0] b;
      int bc;

      #1 reset = 1'b1;
      #1;
      chk("rst_data", data, 0);
      chk("rst_valid", dataValid, 0);
      chk("rst_fe", frameError, 0);
      chk("rst_ov", overrun, 0);
      chk("rst_busy", busy, 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      drive_level(1'b1, 20);

      // Good frame 0xA5 with latency measurement from the start edge
      model_good(8'hA5, 1'b0);
      lat = 0;
      fork
         send_frame(8'hA5, BIT);
         begin
            @(negedge clock);
            while (lat < 3000) begin
               @(posedge clock);
               lat++;
               @(negedge clock);
               if (dataValid) break;
            end
         end
      join
      chk("a5_latency_ok", (lat >= 1515 && lat <= 1560), 1);
      chk("a5_data", data, 8'hA5);
      chk("a5_fe", frameError, 0);
      do_read();
      chk("a5_read_clears", dataValid, 0);
      drive_level(1'b1, 30);

      // Short low glitch on an idle line
      drive_level(1'b0, 20);
      chk("glitch_busy_high", busy, 1);
      drive_level(1'b0, 20);
      drive_level(1'b1, 200);
      chk("glitch_busy_low", busy, 0);
      chk("glitch_dv", dataValid, 0);
      chk("glitch_fe", frameError, 0);

      // 0x3C with stop bit held low for three bit times, then 0x81
      model_bad();
      send_data(8'h3C, BIT);
      drive_level(1'b0, 470);
      chk("brk_fe", frameError, 1);
      chk("brk_dv", dataValid, 0);
      chk("brk_busy", busy, 1);
      drive_level(1'b0, 10);
      drive_level(1'b1, BIT);
      model_good(8'h81, 1'b0);
      send_frame(8'h81, BIT);
      chk("r81_data", data, 8'h81);
      chk("r81_fe", frameError, 0);
      do_read();
      drive_level(1'b1, 30);

      // Back-to-back frames with no read
      model_good(8'h11, 1'b0);
      send_frame(8'h11, BIT);
      model_good(8'h22, 1'b0);
      send_frame(8'h22, BIT);
      chk("ovr_data", data, 8'h11);
      chk("ovr_flag", overrun, 1);
      do_read();
      chk("ovr_clr_dv", dataValid, 0);
      chk("ovr_clr_flag", overrun, 0);
      drive_level(1'b1, 30);

      // Read coinciding with the stop vote while 0x11 is still held
      model_good(8'h11, 1'b0);
      send_frame(8'h11, BIT);
      drive_level(1'b1, 30);
      model_good(8'h55, 1'b1);
      fork
         send_frame(8'h55, BIT);
         begin
            @(negedge clock);
            repeat (1532) @(posedge clock);
            @(negedge clock);
            read = 1'b1;
            @(negedge clock);
            read = 1'b0;
         end
      join
      chk("rsame_data", data, 8'h55);
      chk("rsame_dv", dataValid, 1);
      chk("rsame_ov", overrun, 0);
      do_read();
      drive_level(1'b1, 30);

      // Reset in the middle of data bit 4 of 0xF0
      b = 8'hF0;
      @(negedge clock);
      drive_level(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive_level(b[i], BIT);
      drive_level(b[4], 80);
      model_reset();
      reset = 1'b1;
      #1;
      chk("mid_rst_data", data, 0);
      chk("mid_rst_dv", dataValid, 0);
      chk("mid_rst_busy", busy, 0);
      rxPin = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      drive_level(1'b1, 50);
      model_good(8'h0F, 1'b0);
      send_frame(8'h0F, BIT);
      chk("post_rst_data", data, 8'h0F);
      do_read();
      drive_level(1'b1, 30);

      // Bit-rate mismatch of -3% and +3%
      model_good(8'hA5, 1'b0);
      send_frame(8'hA5, 155);
      chk("fast_data", data, 8'hA5);
      do_read();
      drive_level(1'b1, 30);
      model_good(8'hA5, 1'b0);
      send_frame(8'hA5, 165);
      chk("slow_data", data, 8'hA5);
      do_read();
      drive_level(1'b1, 30);

      // Randomized frames, rates, stop faults and reads
      for (int n = 0; n < 14; n++) begin
         b  = 8'($urandom_range(0, 255));
         bc = $urandom_range(155, 165);
         if ($urandom_range(0, 4) == 0) begin
            model_bad();
            send_data(b, bc);
            drive_level(1'b0, bc);
            drive_level(1'b1, bc);
         end else begin
            model_good(b, 1'b0);
            send_frame(b, bc);
         end
         drive_level(1'b1, $urandom_range(5, 40));
         if ($urandom_range(0, 1) == 1) do_read();
      end

      w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(negedge clock);
         w++;
      end
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
